sfifo_wr_arbiter: RTL and testbench

//   Shares the single write port of one sfifo between N requesters.

---
 rtl/sfifo_wr_arbiter.sv | 109 ++++++++++
 tb/tb_sfifo_wr_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfifo_wr_arbiter.sv
// rtl/sfifo_wr_arbiter.sv - round-robin, burst-locked arbiter sharing one sfifo write port
// Optional build macro WRARB_PRIO0_EN: requester 0 wins every idle arbitration it takes part in.
module sfifo_wr_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 4,
  localparam int OW   = (N > 1) ? $clog2(N) : 1,
  localparam int CW   = $clog2(BURST) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req_valid,
  input  logic [N*WIDTH-1:0] req_data,
  output logic [N-1:0]       req_ready,
  input  logic               fifo_wfull,
  output logic               fifo_winc,
  output logic [WIDTH-1:0]   fifo_wdata,
  output logic [OW-1:0]      owner,
  output logic               busy
);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t        state, state_nx;
  logic [OW-1:0] rr_ptr, rr_nx, owner_nx, pick, owner_inc, cand;
  logic [CW-1:0] beat_cnt, cnt_nx;
  logic          found, own_valid, rel;

  assign busy       = (state == ST_BURST);
  assign own_valid  = req_valid[owner];
  assign fifo_winc  = busy & own_valid & ~fifo_wfull;
  assign fifo_wdata = req_data[owner*WIDTH +: WIDTH];
  assign owner_inc  = (owner == OW'(N - 1)) ? '0 : owner + OW'(1);

  always_comb begin
    req_ready = '0;
    if (busy && !fifo_wfull) req_ready[owner] = 1'b1;
  end

  // Scan from the far end so the index closest to rr_ptr is written last and wins.
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = OW'((int'(rr_ptr) + k) % N);
      if (req_valid[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
`ifdef WRARB_PRIO0_EN
    if (req_valid[0]) begin
      pick  = '0;
      found = 1'b1;
    end
`endif
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    rr_nx    = rr_ptr;
    cnt_nx   = beat_cnt;
    rel      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (found) begin
          state_nx = ST_BURST;
          owner_nx = pick;
          cnt_nx   = '0;
        end
      end
      ST_BURST: begin
        if (!own_valid) begin
          rel = 1'b1;
        end else if (fifo_winc) begin
          cnt_nx = beat_cnt + CW'(1);
          if (beat_cnt == CW'(BURST - 1)) rel = 1'b1;
        end
        if (rel) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
          rr_nx    = owner_inc;
`ifdef WRARB_PRIO0_EN
          // Requester 0 is always granted by override here, so its bursts leave rr_ptr alone.
          if (owner == '0) rr_nx = rr_ptr;
`endif
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nx;
      owner    <= owner_nx;
      rr_ptr   <= rr_nx;
      beat_cnt <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_sfifo_wr_arbiter.sv
// tb/tb_sfifo_wr_arbiter.sv - vector table, directed corner sequences and random run against a reference model
`timescale 1ns/1ps
module tb_sfifo_wr_arbiter;
  localparam int N = 4, WIDTH = 8, BURST = 4, DEPTH = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N-1:0]       req_valid, req_ready;
  logic [N*WIDTH-1:0] req_data;
  logic               fifo_wfull, fifo_winc;
  logic [WIDTH-1:0]   fifo_wdata;
  logic [1:0]         owner;
  logic               busy;

  sfifo_wr_arbiter #(.N(N), .WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_wfull(fifo_wfull), .fifo_winc(fifo_winc),
    .fifo_wdata(fifo_wdata), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who holds the port, how many beats of budget remain, where the search starts
  int m_busy, m_owner, m_left, m_rr;
  logic [7:0] sbuf [N][4096];
  int         sh [N], st [N];
  logic [7:0] fq[$], efq[$];
  int         grants[$];
  bit         wlog[$];
  logic [N-1:0] vmask, acc_prev;
  bit         prev_busy;

  task automatic refill(int i, int n);
    for (int k = 0; k < n; k++) begin
      sbuf[i][st[i]] = 8'($urandom);
      st[i]++;
    end
  endtask

  // A beat that is valid and not yet accepted stays valid with the same data.
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bit keep;
      keep = req_valid[i] && !acc_prev[i];
      req_valid[i] = keep || (vmask[i] && sh[i] != st[i]);
      req_data[i*WIDTH +: WIDTH] = (sh[i] != st[i]) ? sbuf[i][sh[i]] : 8'h00;
    end
    fifo_wfull = (fq.size() >= DEPTH);
  endtask

  task automatic m_release();
    m_busy = 0;
`ifdef WRARB_PRIO0_EN
    if (m_owner != 0) m_rr = (m_owner + 1) % N;
`else
    m_rr = (m_owner + 1) % N;
`endif
  endtask

  task automatic step(bit do_pop);
    int  vv, ev, pick;
    bit  ew, dut_w;
    logic [7:0] dut_wd, a, e;
    @(negedge clk);
    vv = int'(req_valid);
    ew = (m_busy != 0) && ((vv >> m_owner) & 1) != 0 && !fifo_wfull;
    ev = (m_busy != 0 && !fifo_wfull) ? (1 << m_owner) : 0;
    chk("busy", int'(busy), m_busy);
    chk("owner", int'(owner), m_owner);
    chk("req_ready", int'(req_ready), ev);
    chk("fifo_winc", int'(fifo_winc), int'(ew));
    if (ew) chk("fifo_wdata", int'(fifo_wdata), int'(sbuf[m_owner][sh[m_owner]]));
    if (busy && !prev_busy) grants.push_back(int'(owner));
    prev_busy = busy;
    wlog.push_back(fifo_winc);
    dut_w  = fifo_winc;
    dut_wd = fifo_wdata;
    acc_prev = '0;
    if (m_busy != 0) begin
      if (((vv >> m_owner) & 1) == 0) begin
        m_release();
      end else if (ew) begin
        acc_prev[m_owner] = 1'b1;
        efq.push_back(sbuf[m_owner][sh[m_owner]]);
        sh[m_owner]++;
        m_left--;
        if (m_left == 0) m_release();
      end
    end else begin
      pick = -1;
      for (int k = N - 1; k >= 0; k--)
        if (((vv >> ((m_rr + k) % N)) & 1) != 0) pick = (m_rr + k) % N;
`ifdef WRARB_PRIO0_EN
      if ((vv & 1) != 0) pick = 0;
`endif
      if (pick >= 0) begin
        m_busy  = 1;
        m_owner = pick;
        m_left  = BURST;
      end
    end
    @(posedge clk);
    #1;
    if (do_pop && fq.size() > 0) begin
      a = fq.pop_front();
      if (efq.size() > 0) begin
        e = efq.pop_front();
        chk("fifo_order", int'(a), int'(e));
      end else begin
        chk("fifo_extra_beat", 1, 0);
      end
    end
    if (dut_w) fq.push_back(dut_wd);
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    vmask = '0;
    req_valid = '0;
    acc_prev = '0;
    repeat (2) @(posedge clk);
    #1;
    m_busy = 0; m_owner = 0; m_rr = 0; m_left = 0; prev_busy = 0;
    fq.delete(); efq.delete(); grants.delete(); wlog.delete();
    for (int i = 0; i < N; i++) begin sh[i] = 0; st[i] = 0; end
    rst_n = 1'b1;
    drive();
  endtask

  typedef struct {
    logic [N-1:0] v; logic [7:0] d1; logic wf;
    logic eb; logic ew; logic [N-1:0] er; logic [1:0] eo;
  } vec_t;
  vec_t tbl[12];
  logic [7:0] wr[$];

  initial begin
    int base, n;
    rst_n = 1'b0; req_valid = '0; req_data = '0; fifo_wfull = 1'b0; vmask = '0; acc_prev = '0;
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_winc", int'(fifo_winc), 0);
    chk("rst_owner", int'(owner), 0);

    // Requester 1 alone: 1-cycle grant latency, 4-beat bursts, 1-cycle bubble, one full stall
    tbl[0]  = '{4'b0010, 8'h10, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0};
    tbl[1]  = '{4'b0010, 8'h10, 1'b0, 1'b1, 1'b1, 4'b0010, 2'd1};
    tbl[2]  = '{4'b0010, 8'h11, 1'b0, 1'b1, 1'b1, 4'b0010, 2'd1};
    tbl[3]  = '{4'b0010, 8'h12, 1'b0, 1'b1, 1'b1, 4'b0010, 2'd1};
    tbl[4]  = '{4'b0010, 8'h13, 1'b0, 1'b1, 1'b1, 4'b0010, 2'd1};
    tbl[5]  = '{4'b0010, 8'h14, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd1};
    tbl[6]  = '{4'b0010, 8'h14, 1'b0, 1'b1, 1'b1, 4'b0010, 2'd1};
    tbl[7]  = '{4'b0010, 8'h15, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd1};
    tbl[8]  = '{4'b0010, 8'h15, 1'b0, 1'b1, 1'b1, 4'b0010, 2'd1};
    tbl[9]  = '{4'b0010, 8'h16, 1'b0, 1'b1, 1'b1, 4'b0010, 2'd1};
    tbl[10] = '{4'b0010, 8'h17, 1'b0, 1'b1, 1'b1, 4'b0010, 2'd1};
    tbl[11] = '{4'b0000, 8'h17, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd1};
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      req_valid  = tbl[i].v;
      req_data   = {8'h00, 8'h00, tbl[i].d1, 8'h00};
      fifo_wfull = tbl[i].wf;
      @(negedge clk);
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].eb));
      chk($sformatf("tbl%0d_winc", i), int'(fifo_winc), int'(tbl[i].ew));
      chk($sformatf("tbl%0d_ready", i), int'(req_ready), int'(tbl[i].er));
      chk($sformatf("tbl%0d_owner", i), int'(owner), int'(tbl[i].eo));
      if (tbl[i].ew) chk($sformatf("tbl%0d_wdata", i), int'(fifo_wdata), int'(tbl[i].d1));
      if (fifo_winc) wr.push_back(fifo_wdata);
      @(posedge clk);
      #1;
    end
    chk("tbl_beats", wr.size(), 8);
    for (int k = 0; k < 8 && k < wr.size(); k++) chk("tbl_order", int'(wr[k]), 8'h10 + k);

    // All four continuously valid: owners rotate, winc pattern 1111_0
    do_reset();
    vmask = 4'b1111;
    for (int i = 0; i < N; i++) refill(i, 20);
    drive();
    repeat (22) step(1'b1);
    chk("rot_grants", grants.size() >= 5, 1);
    for (int g = 0; g < 5 && g < grants.size(); g++) chk("rot_owner", grants[g], g % N);
    for (int c = 0; c < 20; c++) chk("rot_winc", int'(wlog[c]), int'(c % 5 != 0));

    // Owner 2 drops valid after 2 beats; next grant goes to 3 even though 0 is valid
    do_reset();
    vmask = 4'b0100;
    refill(2, 8); refill(0, 4); refill(3, 4);
    drive();
    n = 0;
    while (sh[2] < 2 && n < 20) begin step(1'b1); n++; end
    chk("drop_reach", int'(sh[2] == 2), 1);
    vmask = 4'b1001;
    drive();
    grants.delete();
    n = 0;
    while (grants.size() == 0 && n < 6) begin step(1'b1); n++; end
    chk("drop_grant_seen", grants.size(), 1);
    if (grants.size() > 0) chk("drop_next_owner", grants[0], 3);
    chk("drop_latency", n, 3);

    // Fill the sfifo with requester 0 and check stall, single accept per pop, then drain
    do_reset();
    vmask = 4'b0001;
    refill(0, 30);
    drive();
    repeat (25) step(1'b0);
    chk("full_level", fq.size(), DEPTH);
    #2;
    chk("full_winc", int'(fifo_winc), 0);
    chk("full_ready", int'(req_ready), 0);
    chk("full_busy", int'(busy), 1);
    step(1'b1);
    repeat (6) step(1'b0);
    chk("full_one_more", sh[0], DEPTH + 1);
    chk("full_level2", fq.size(), DEPTH);
    vmask = '0;
    drive();
    repeat (25) step(1'b1);
    chk("drain_empty", fq.size(), 0);
    chk("drain_expected_empty", efq.size(), 0);

    // Reset mid-burst of owner 3 after 2 beats; arbitration restarts from requester 0
    do_reset();
    vmask = 4'b1010;
    refill(1, 10); refill(3, 10);
    drive();
    n = 0;
    while (sh[3] < 2 && n < 30) begin step(1'b1); n++; end
    chk("mid_reach", int'(sh[3] == 2), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_busy", int'(busy), 0);
    chk("mid_ready", int'(req_ready), 0);
    chk("mid_winc", int'(fifo_winc), 0);
    @(posedge clk);
    #1;
    m_busy = 0; m_owner = 0; m_rr = 0; m_left = 0; prev_busy = 0;
    acc_prev = '0;
    rst_n = 1'b1;
    drive();
    grants.delete();
    n = 0;
    while (grants.size() == 0 && n < 5) begin step(1'b1); n++; end
    chk("mid_grant_seen", grants.size(), 1);
    if (grants.size() > 0) chk("mid_restart_owner", grants[0], 1);

    // Requesters 0 and 2 continuously valid, rr pointer at 1 after the first burst
    do_reset();
    vmask = 4'b0101;
    refill(0, 30); refill(2, 30);
    drive();
    repeat (35) step(1'b1);
    chk("pair_grants", grants.size() >= 5, 1);
    for (int g = 1; g < 5 && g < grants.size(); g++)
`ifdef WRARB_PRIO0_EN
      chk("pair_owner", grants[g], 0);
`else
      chk("pair_owner", grants[g], (g % 2 == 1) ? 2 : 0);
`endif

    // Random traffic with varying sfifo drain rate
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      int pct;
      pct = ((c / 200) % 2 == 0) ? 90 : 30;
      vmask = N'($urandom);
      for (int i = 0; i < N; i++) if (st[i] - sh[i] < 3) refill(i, 3);
      drive();
      step($urandom_range(0, 99) < pct);
    end
    vmask = '0;
    drive();
    repeat (60) step(1'b1);
    chk("rand_drain_empty", fq.size(), 0);
    chk("rand_expected_empty", efq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
